// File: rtl/rtype_issue.sv
// Issue/writeback sequencer in front of the R-type ALU, with a 32x32
// register file. One instruction in flight: IDLE -> EXEC -> WB.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   instr_valid/_ready   instruction handshake, instr = 32-bit R-type word
//   alu_a, alu_b         registered operands R[rs], R[rt] to the ALU
//   alu_code, alu_shamt  registered funct and shamt to the ALU
//   alu_out              combinational ALU result
//   wb_valid/_rd/_data   one-cycle writeback pulse with destination and value
//   illegal              one-cycle pulse after an unsupported transfer
//   dbg_addr, dbg_data   combinational register-file read port
module rtype_issue #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_code,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_code_q, alu_code_d;
    logic [4:0]  alu_shamt_q, alu_shamt_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        illegal_q, illegal_d;

    logic [5:0]  f_opcode;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [4:0]  f_shamt;
    logic [5:0]  f_funct;
    logic        funct_ok;
    logic        legal;
    logic        xfer;

    assign f_opcode = instr[31:26];
    assign f_rs     = instr[25:21];
    assign f_rt     = instr[20:16];
    assign f_rd     = instr[15:11];
    assign f_shamt  = instr[10:6];
    assign f_funct  = instr[5:0];

    // Supported functs: add, sub, and, or, sll, srl, sra.
    always_comb begin
        funct_ok = 1'b0;
        case (f_funct)
            6'h20,
            6'h22,
            6'h24,
            6'h25,
            6'h00,
            6'h02,
            6'h03:   funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    assign legal       = (f_opcode == 6'd0) && funct_ok;
    assign instr_ready = (state_q == IDLE) && rst_n;
    assign xfer        = instr_valid && instr_ready;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_code_d  = alu_code_q;
        alu_shamt_d = alu_shamt_q;
        rd_d        = rd_q;
        result_d    = result_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        illegal_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (legal) begin
                        // R0 reads as zero even though it is never written.
                        alu_a_d     = (f_rs == 5'd0) ? 32'd0 : regs_q[f_rs];
                        alu_b_d     = (f_rt == 5'd0) ? 32'd0 : regs_q[f_rt];
                        alu_code_d  = f_funct;
                        alu_shamt_d = f_shamt;
                        rd_d        = f_rd;
                        state_d     = EXEC;
                    end else begin
                        // Reject: keep operands, stay ready.
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                result_d   = alu_out;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = alu_out;
                state_d    = WB;
            end
            WB: begin
                if (rd_q != 5'd0) begin
                    regs_d[rd_q] = result_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_code_q  <= 6'd0;
            alu_shamt_q <= 5'd0;
            rd_q        <= 5'd0;
            result_q    <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_code_q  <= alu_code_d;
            alu_shamt_q <= alu_shamt_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_code  = alu_code_q;
    assign alu_shamt = alu_shamt_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign illegal   = illegal_q;

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_rtype_issue.sv
// Testbench for rtype_issue: behavioural ALU, reference register file,
// writeback scoreboard checked by an independent monitor.
module tb_rtype_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_code;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    rtype_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_code    (alu_code),
        .alu_shamt   (alu_shamt),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ill_pending = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    // Behavioural ALU; the override lets the bench inject preload values.
    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [5:0] f,
                                          input logic [4:0] sh);
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h00:   return b << sh;
            6'h02:   return b >> sh;
            6'h03:   return $unsigned($signed(b) >>> sh);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out = ovr_en ? ovr_val
                            : alu_f(alu_a, alu_b, alu_code, alu_shamt);

    function automatic logic [31:0] rtype(input int rs, input int rt,
                                          input int rd, input int sh,
                                          input logic [5:0] f);
        logic [4:0] a, b, d, s;
        a = rs[4:0];
        b = rt[4:0];
        d = rd[4:0];
        s = sh[4:0];
        return {6'd0, a, b, d, s, f};
    endfunction

    function automatic bit is_legal(input logic [31:0] w);
        logic [5:0] f;
        f = w[5:0];
        if (w[31:26] != 6'd0) return 1'b0;
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 ||
               f == 6'h00 || f == 6'h02 || f == 6'h03;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h",
                             wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_latency", cyc, e.cyc);
                end
            end
            if (illegal) begin
                n_tests++;
                if (ill_pending == 0) begin
                    n_fail++;
                    $display("FAIL illegal_unexpected: got 1 expected 0");
                end else begin
                    ill_pending--;
                end
            end
        end
    end

    // Present an instruction, wait (bounded) for the transfer, record the
    // expected outcome. Returns at transfer edge + 1 with the wait count.
    task automatic issue(input logic [31:0] w, input bit oe,
                         input logic [31:0] ov, input bit hold,
                         output int waited);
        logic [4:0]  rs, rt, rd;
        logic [31:0] ea, eb;
        bit          lg;
        exp_t        e;
        waited = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
            instr_valid = 1'b0;
            return;
        end
        ovr_en = oe;
        ovr_val = ov;
        rs = w[25:21];
        rt = w[20:16];
        rd = w[15:11];
        lg = is_legal(w);
        ea = ref_regs[rs];
        eb = ref_regs[rt];
        if (lg) begin
            e.rd = rd;
            e.data = oe ? ov : alu_f(ea, eb, w[5:0], w[10:6]);
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            if (rd != 5'd0) ref_regs[rd] = e.data;
        end else begin
            ill_pending++;
        end
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        if (lg) begin
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_code", {26'd0, alu_code}, {26'd0, w[5:0]});
            chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, w[10:6]});
            chk("ready_busy", {31'd0, instr_ready}, 32'd0);
        end else begin
            chk("illegal_pulse", {31'd0, illegal}, 32'd1);
            chk("ready_after_illegal", {31'd0, instr_ready}, 32'd1);
        end
    endtask

    task automatic go(input logic [31:0] w);
        int n;
        issue(w, 1'b0, 32'd0, 1'b0, n);
    endtask

    task automatic preload(input int rd, input logic [31:0] v);
        int n;
        issue(rtype(0, 0, rd, 0, 6'h20), 1'b1, v, 1'b0, n);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got 0 expected 1");
        end
    endtask

    task automatic check_regs();
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            chk($sformatf("dbg_r%0d", i), dbg_data,
                (i == 0) ? 32'd0 : ref_regs[i]);
        end
    endtask

    task automatic chk_reg(input int a, input logic [31:0] v);
        wait_idle();
        dbg_addr = a[4:0];
        #1;
        chk($sformatf("reg_r%0d", a), dbg_data, v);
    endtask

    logic [5:0] functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25,
                               6'h00, 6'h02, 6'h03};

    initial begin
        int n;
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instr = rtype(1, 2, 3, 0, 6'h20);
        dbg_addr = 5'd0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_code", {26'd0, alu_code}, 32'd0);
        chk("rst_shamt", {27'd0, alu_shamt}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #0.1;
            chk("rst_dbg", dbg_data, 32'd0);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);
        mon_en = 1'b1;

        preload(1, 32'hA);
        preload(2, 32'h5);
        preload(5, 32'h8000_0000);
        wait_idle();

        go(rtype(1, 2, 3, 0, 6'h20));
        chk_reg(3, 32'hF);
        go(rtype(2, 1, 4, 0, 6'h22));
        chk_reg(4, 32'hFFFF_FFFB);
        go(rtype(0, 5, 8, 5, 6'h00));
        chk_reg(8, 32'h0);
        go(rtype(0, 5, 9, 5, 6'h02));
        chk_reg(9, 32'h0400_0000);
        go(rtype(0, 5, 10, 5, 6'h03));
        chk_reg(10, 32'hFC00_0000);
        go(rtype(1, 2, 11, 0, 6'h24));
        chk_reg(11, 32'h0);
        go(rtype(1, 2, 12, 0, 6'h25));
        chk_reg(12, 32'hF);
        go(rtype(1, 2, 0, 0, 6'h25));
        chk_reg(0, 32'h0);

        wait_idle();
        go({6'h08, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20});
        go(rtype(1, 2, 13, 0, 6'h26));
        check_regs();

        wait_idle();
        issue(rtype(1, 2, 6, 0, 6'h20), 1'b0, 32'd0, 1'b1, n);
        issue(rtype(6, 6, 7, 0, 6'h20), 1'b0, 32'd0, 1'b0, n);
        chk("b2b_spacing", n, 3);
        chk_reg(7, 32'h1E);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] w;
            int sel;
            sel = $urandom_range(7);
            w = rtype($urandom_range(31), $urandom_range(31),
                      $urandom_range(31), $urandom_range(31),
                      functs[$urandom_range(6)]);
            if (sel == 0) w[31:26] = 6'($urandom_range(63, 1));
            if (sel == 1) w[5:0] = 6'h26;
            issue(w, ($urandom_range(3) == 0), $urandom, 1'b0, n);
        end
        check_regs();

        wait_idle();
        go(rtype(1, 2, 14, 0, 6'h20));
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        repeat (2) @(negedge clk);
        chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_regs();

        repeat (3) @(negedge clk);
        chk("wb_queue_empty", exp_q.size(), 32'd0);
        chk("illegal_all_seen", ill_pending, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
